// File: rtl/quaddec.sv
// quaddec: quadrature encoder front end. It synchronizes and glitch-filters A/B,
// decodes steps into a signed position count, and flags illegal transitions.
// Define QUADDEC_INDEX_EN to build the index channel. The index channel zeroes
// the position on a filtered rising edge and sets idxseen.
module quaddec #(
    parameter int unsigned COUNTW    = 16,
    parameter int unsigned FILTDEPTH = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              filterce,
    input  logic              invphase,
    input  logic              quada,
    input  logic              quadb,
    input  logic              quadidx,
    input  logic              clrpos,
    input  logic              errclr,
    input  logic              poslatch,
    output logic [COUNTW-1:0] position,
    output logic [COUNTW-1:0] poshold,
    output logic              dir,
    output logic              quaderr,
    output logic              idxseen
);

`ifdef QUADDEC_INDEX_EN
    localparam int unsigned NCH    = 3;
    localparam int unsigned CH_IDX = 2;
`else
    localparam int unsigned NCH    = 2;
`endif
    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_PRIMED   = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] filt;
    logic [1:0]     ab;
    logic [1:0]     prev;
    logic [1:0]     phase_diff;
    logic           step_valid;
    logic           step_up;
    logic           illegal;
    logic           idx_rise;

`ifdef QUADDEC_INDEX_EN
    assign raw = {quadidx, quadb, quada};
`else
    logic unused_quadidx;
    assign unused_quadidx = quadidx;
    assign raw = {quadb, quada};
`endif

    // Gray state {A,B} to sequence position: 00->0, 10->1, 11->2, 01->3.
    function automatic logic [1:0] phase_of(input logic [1:0] s);
        return {s[0], s[1] ^ s[0]};
    endfunction

    // Two-flop synchronizers for the asynchronous encoder inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_filt
        logic [FILTDEPTH-1:0] hist;
        logic [FILTDEPTH-1:0] hist_nxt;
        logic                 lvl;
        logic                 lvl_nxt;

        // A new level is accepted only once the whole history agrees.
        always_comb begin
            hist_nxt = {hist[FILTDEPTH-2:0], sync2[g]};
            lvl_nxt  = lvl;
            if (&hist_nxt) begin
                lvl_nxt = 1'b1;
            end else if (~|hist_nxt) begin
                lvl_nxt = 1'b0;
            end
        end

        // The history and level advance only on filter strobes.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                hist <= '0;
                lvl  <= 1'b0;
            end else if (filterce) begin
                hist <= hist_nxt;
                lvl  <= lvl_nxt;
            end
        end

        assign filt[g] = lvl;
    end

    assign ab = {filt[CH_A], filt[CH_B]};

    // Priming state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_UNPRIMED;
        end else begin
            state <= state_nxt;
        end
    end

    // Step decode. The first filtered change after reset only primes prev.
    always_comb begin
        state_nxt  = state;
        step_valid = 1'b0;
        step_up    = 1'b0;
        illegal    = 1'b0;
        phase_diff = phase_of(ab) - phase_of(prev);
        case (state)
            ST_UNPRIMED: begin
                if (ab != prev) begin
                    state_nxt = ST_PRIMED;
                end
            end
            ST_PRIMED: begin
                case (phase_diff)
                    2'd1: begin
                        step_valid = 1'b1;
                        step_up    = ~invphase;
                    end
                    2'd3: begin
                        step_valid = 1'b1;
                        step_up    = invphase;
                    end
                    2'd2:    illegal = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

`ifdef QUADDEC_INDEX_EN
    logic idx_prev;

    // Index rising-edge detect and sticky seen flag. A set beats a clrpos clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_prev <= 1'b0;
            idxseen  <= 1'b0;
        end else begin
            idx_prev <= filt[CH_IDX];
            if (idx_rise) begin
                idxseen <= 1'b1;
            end else if (clrpos) begin
                idxseen <= 1'b0;
            end
        end
    end

    assign idx_rise = (state == ST_PRIMED) && filt[CH_IDX] && !idx_prev;
`else
    assign idx_rise = 1'b0;
    assign idxseen  = 1'b0;
`endif

    // Position counter, snapshot, direction and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev     <= '0;
            position <= '0;
            poshold  <= '0;
            dir      <= 1'b0;
            quaderr  <= 1'b0;
        end else begin
            prev <= ab;
            if (poslatch) begin
                poshold <= position;
            end
            if (clrpos || idx_rise) begin
                position <= '0;
            end else if (step_valid) begin
                position <= step_up ? position + COUNTW'(1) : position - COUNTW'(1);
            end
            if (step_valid) begin
                dir <= step_up;
            end
            if (illegal) begin
                quaderr <= 1'b1;
            end else if (errclr) begin
                quaderr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quaddec.sv
// tb_quaddec: randomized self-checking bench for quaddec.
// It uses a position/direction model kept as plain integers.
module tb_quaddec;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        filterce = 1'b0;
    logic        invphase = 1'b0;
    logic        quada = 1'b1;
    logic        quadb = 1'b1;
    logic        quadidx = 1'b0;
    logic        clrpos = 1'b0;
    logic        errclr = 1'b0;
    logic        poslatch = 1'b0;
    logic [15:0] position;
    logic [15:0] poshold;
    logic        dir;
    logic        quaderr;
    logic        idxseen;
    logic [7:0]  position8;
    logic [7:0]  poshold8;
    logic        dir8;
    logic        quaderr8;
    logic        idxseen8;

    int checks = 0;
    int errors = 0;
    int fce_every = 4;
    int fcnt = 0;
    int enc_phase = 2;
    int exp_pos = 0;
    logic exp_dir = 1'b0;
    // Encoder forward sequence as {A,B}.
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quaddec #(.COUNTW(16), .FILTDEPTH(3)) dut (
        .clk(clk), .rstn(rstn), .filterce(filterce), .invphase(invphase),
        .quada(quada), .quadb(quadb), .quadidx(quadidx), .clrpos(clrpos),
        .errclr(errclr), .poslatch(poslatch), .position(position),
        .poshold(poshold), .dir(dir), .quaderr(quaderr), .idxseen(idxseen)
    );

    quaddec #(.COUNTW(8), .FILTDEPTH(3)) dut8 (
        .clk(clk), .rstn(rstn), .filterce(filterce), .invphase(invphase),
        .quada(quada), .quadb(quadb), .quadidx(quadidx), .clrpos(clrpos),
        .errclr(errclr), .poslatch(poslatch), .position(position8),
        .poshold(poshold8), .dir(dir8), .quaderr(quaderr8), .idxseen(idxseen8)
    );

    always #5 clk = ~clk;

    // Filter strobe: one clk every fce_every clks.
    always @(negedge clk) begin
        fcnt = fcnt + 1;
        filterce = ((fcnt % fce_every) == 0);
    end

    task automatic do_step(input bit fwd, input int hold);
        enc_phase = fwd ? (enc_phase + 1) % 4 : (enc_phase + 3) % 4;
        {quada, quadb} = gray[enc_phase];
        if (fwd ^ invphase) exp_pos = exp_pos + 1;
        else exp_pos = exp_pos - 1;
        exp_dir = fwd ^ invphase;
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_clear();
        clrpos = 1'b1;
        @(negedge clk);
        clrpos = 1'b0;
        exp_pos = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        quada = 1'b1;
        quadb = 1'b1;
        enc_phase = 2;
        repeat (3) @(negedge clk);
        checks++; if (position !== 16'h0) begin errors++; $display("FAIL rst_position: got %h expected 0000", position); end
        checks++; if (poshold !== 16'h0) begin errors++; $display("FAIL rst_poshold: got %h expected 0000", poshold); end
        checks++; if ({dir, quaderr, idxseen} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {dir, quaderr, idxseen}); end
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        exp_pos = 0;
        checks++; if (position !== 16'h0) begin errors++; $display("FAIL prime_position: got %h expected 0000", position); end
        checks++; if (quaderr !== 1'b0) begin errors++; $display("FAIL prime_quaderr: got %b expected 0", quaderr); end
    endtask

    task automatic test_forward_reverse();
        for (int pass = 0; pass < 2; pass++) begin
            invphase = (pass == 1);
            for (int i = 0; i < 8; i++) begin
                do_step(1'b1, 16);
                checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL fwd_step: got %h expected %h", position, 16'(exp_pos)); end
            end
            checks++; if (position !== ((pass == 1) ? 16'hFFF8 : 16'h0008)) begin errors++; $display("FAIL fwd_total: got %h pass %0d", position, pass); end
            checks++; if (dir !== (pass == 0)) begin errors++; $display("FAIL fwd_dir: got %b pass %0d", dir, pass); end
            for (int i = 0; i < 10; i++) begin
                do_step(1'b0, 16);
                checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL rev_step: got %h expected %h", position, 16'(exp_pos)); end
            end
            checks++; if (position !== ((pass == 1) ? 16'h0002 : 16'hFFFE)) begin errors++; $display("FAIL rev_total: got %h pass %0d", position, pass); end
            checks++; if (dir !== (pass == 1)) begin errors++; $display("FAIL rev_dir: got %b pass %0d", dir, pass); end
            do_clear();
        end
        invphase = 1'b0;
    endtask

    task automatic test_random_walk();
        for (int i = 0; i < 40; i++) begin
            fce_every = int'($urandom_range(1, 4));
            invphase = 1'($urandom_range(0, 1));
            do_step(1'($urandom_range(0, 1)), 5 * fce_every + 4);
            checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL walk_pos: got %h expected %h", position, 16'(exp_pos)); end
            checks++; if (position8 !== 8'(exp_pos)) begin errors++; $display("FAIL walk_pos8: got %h expected %h", position8, 8'(exp_pos)); end
            checks++; if ({dir, dir8} !== {exp_dir, exp_dir}) begin errors++; $display("FAIL walk_dir: got %b%b expected %b", dir, dir8, exp_dir); end
        end
        fce_every = 4;
        invphase = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_glitch();
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (n % 2 == 0) quada = ~quada;
            else quadb = ~quadb;
            repeat (4) @(negedge clk);
            {quada, quadb} = gray[enc_phase];
            repeat (20) @(negedge clk);
            checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL glitch_pos: got %h expected %h", position, 16'(exp_pos)); end
            checks++; if (quaderr !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b expected 0", quaderr); end
        end
    endtask

    task automatic test_illegal();
        enc_phase = (enc_phase + 2) % 4;
        {quada, quadb} = gray[enc_phase];
        repeat (24) @(negedge clk);
        checks++; if ({quaderr, quaderr8} !== 2'b11) begin errors++; $display("FAIL illegal_set: got %b%b expected 11", quaderr, quaderr8); end
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL illegal_pos: got %h expected %h", position, 16'(exp_pos)); end
        checks++; if (dir !== exp_dir) begin errors++; $display("FAIL illegal_dir: got %b expected %b", dir, exp_dir); end
        errclr = 1'b1;
        @(negedge clk);
        errclr = 1'b0;
        checks++; if (quaderr !== 1'b0) begin errors++; $display("FAIL errclr: got %b expected 0", quaderr); end
        do_step(1'b1, 24);
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL post_illegal_pos: got %h expected %h", position, 16'(exp_pos)); end
        checks++; if (quaderr !== 1'b0) begin errors++; $display("FAIL post_illegal_err: got %b expected 0", quaderr); end
    endtask

    task automatic test_wrap();
        fce_every = 1;
        do_clear();
        for (int i = 0; i < 127; i++) do_step(1'b1, 9);
        checks++; if (position8 !== 8'h7F) begin errors++; $display("FAIL wrap_pre8: got %h expected 7f", position8); end
        do_step(1'b1, 9);
        checks++; if (position8 !== 8'h80) begin errors++; $display("FAIL wrap_max8: got %h expected 80", position8); end
        checks++; if (position !== 16'h0080) begin errors++; $display("FAIL wrap_16: got %h expected 0080", position); end
        do_clear();
        do_step(1'b0, 9);
        checks++; if (position !== 16'hFFFF) begin errors++; $display("FAIL wrap_under: got %h expected ffff", position); end
        checks++; if (position8 !== 8'hFF) begin errors++; $display("FAIL wrap_under8: got %h expected ff", position8); end
    endtask

    task automatic test_simultaneous();
        int pre;
        // Exact latency with a strobe every clk: position moves on the 6th edge.
        pre = exp_pos;
        do_step(1'b1, 5);
        checks++; if (position !== 16'(pre)) begin errors++; $display("FAIL latency_early: got %h expected %h", position, 16'(pre)); end
        @(negedge clk);
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL latency_edge: got %h expected %h", position, 16'(exp_pos)); end
        do_step(1'b1, 9);
        do_step(1'b1, 9);
        pre = exp_pos;
        do_step(1'b1, 5);
        clrpos = 1'b1;
        poslatch = 1'b1;
        @(negedge clk);
        clrpos = 1'b0;
        poslatch = 1'b0;
        exp_pos = 0;
        checks++; if (position !== 16'h0) begin errors++; $display("FAIL clr_wins: got %h expected 0000", position); end
        checks++; if (poshold !== 16'(pre)) begin errors++; $display("FAIL latch_pre: got %h expected %h", poshold, 16'(pre)); end
        checks++; if (poshold8 !== 8'(pre)) begin errors++; $display("FAIL latch_pre8: got %h expected %h", poshold8, 8'(pre)); end
        repeat (6) @(negedge clk);
        do_step(1'b0, 9);
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL after_clr_step: got %h expected %h", position, 16'(exp_pos)); end
        checks++; if (quaderr !== 1'b0) begin errors++; $display("FAIL after_clr_err: got %b expected 0", quaderr); end
    endtask

    task automatic test_index();
        fce_every = 1;
        do_clear();
        for (int i = 0; i < 37; i++) do_step(1'b1, 9);
        checks++; if (position !== 16'd37) begin errors++; $display("FAIL idx_pre: got %h expected 0025", position); end
        quadidx = 1'b1;
        repeat (12) @(negedge clk);
`ifdef QUADDEC_INDEX_EN
        exp_pos = 0;
        checks++; if (position !== 16'h0) begin errors++; $display("FAIL idx_zero: got %h expected 0000", position); end
        checks++; if ({idxseen, idxseen8} !== 2'b11) begin errors++; $display("FAIL idx_seen: got %b%b expected 11", idxseen, idxseen8); end
        quadidx = 1'b0;
        repeat (12) @(negedge clk);
        do_clear();
        checks++; if (idxseen !== 1'b0) begin errors++; $display("FAIL idx_clr: got %b expected 0", idxseen); end
`else
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL idx_ignored: got %h expected %h", position, 16'(exp_pos)); end
        checks++; if ({idxseen, idxseen8} !== 2'b00) begin errors++; $display("FAIL idx_tied: got %b%b expected 00", idxseen, idxseen8); end
        quadidx = 1'b0;
        repeat (12) @(negedge clk);
`endif
        do_step(1'b1, 9);
        checks++; if (position !== 16'(exp_pos)) begin errors++; $display("FAIL idx_resume: got %h expected %h", position, 16'(exp_pos)); end
    endtask

    task automatic test_reset_midop();
        do_step(1'b1, 9);
        do_step(1'b1, 9);
        poslatch = 1'b1;
        @(negedge clk);
        poslatch = 1'b0;
        checks++; if (poshold !== 16'(exp_pos)) begin errors++; $display("FAIL latch_only: got %h expected %h", poshold, 16'(exp_pos)); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (position !== 16'h0 || poshold !== 16'h0) begin errors++; $display("FAIL midrst_regs: got %h %h expected 0000 0000", position, poshold); end
        checks++; if ({dir, quaderr, idxseen} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {dir, quaderr, idxseen}); end
        enc_phase = 2;
        {quada, quadb} = gray[enc_phase];
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        exp_pos = 0;
        repeat (20) @(negedge clk);
        checks++; if (position !== 16'h0 || quaderr !== 1'b0) begin errors++; $display("FAIL reprime: got %h err %b expected 0000 err 0", position, quaderr); end
        do_step(1'b1, 9);
        checks++; if (position !== 16'h0001) begin errors++; $display("FAIL reprime_step: got %h expected 0001", position); end
    endtask

    initial begin
        test_reset();
        test_forward_reverse();
        test_random_walk();
        test_glitch();
        test_illegal();
        test_wrap();
        test_simultaneous();
        test_index();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
